// File: rtl/squareroot_mahsqr_pkg.sv
// Shared widths, types and helpers for the MAHSQR K=6 square-root block.
// Build option: MAHSQR_EXACT_LSB_EN selects a fully exact 8-bit root.
package squareroot_mahsqr_pkg;

    localparam int IN_W  = 16;
    localparam int OUT_W = IN_W / 2;
    localparam int K     = 6;

    typedef logic [IN_W-1:0]  radicand_t;
    typedef logic [OUT_W-1:0] root_t;
    typedef logic [8:0]       rem_t;

    // Exact root of a 4-bit value, used when the upper radicand bits are zero.
    function automatic logic [1:0] nibble_root(input logic [3:0] n);
        logic [1:0] r;
        if (n >= 4'd9) begin
            r = 2'd3;
        end else if (n >= 4'd4) begin
            r = 2'd2;
        end else if (n >= 4'd1) begin
            r = 2'd1;
        end else begin
            r = 2'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sqrt_rec_step.sv
// One restoring digit-recurrence step: consumes two radicand bits and
// produces one more root bit plus the updated partial remainder.
module sqrt_rec_step
    import squareroot_mahsqr_pkg::*;
(
    input  logic [8:0] part_rem,
    input  logic [7:0] part_root,
    input  logic [1:0] rad_bits,
    output logic [8:0] new_rem,
    output logic [7:0] new_root
);

    logic [10:0] acc;
    logic [10:0] trial;
    logic [10:0] diff;

    assign acc   = {part_rem, rad_bits};
    assign trial = {1'b0, part_root, 2'b01};
    assign diff  = acc - trial;

    always_comb begin
        new_rem  = rem_t'(acc);
        new_root = root_t'({part_root, 1'b0});
        if (acc >= trial) begin
            new_rem  = rem_t'(diff);
            new_root = root_t'({part_root, 1'b1});
        end
    end

endmodule

// File: rtl/squareroot_mahsqr_k6.sv
// Approximate 16-bit square root for Sobel magnitude, registered 8-bit output.
// Build option: MAHSQR_EXACT_LSB_EN replaces the 2-bit approximation with exact steps.
module squareroot_mahsqr_k6
    import squareroot_mahsqr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] R,
    output logic [7:0]  final_op
);

`ifdef MAHSQR_EXACT_LSB_EN
    localparam int N_STEPS = OUT_W;
`else
    localparam int N_STEPS = K;
`endif

    rem_t  rem_c  [0:N_STEPS];
    root_t root_c [0:N_STEPS];
    root_t root_nxt;

    assign rem_c[0]  = '0;
    assign root_c[0] = '0;

    for (genvar i = 0; i < N_STEPS; i++) begin : g_step
        sqrt_rec_step u_step (
            .part_rem  (rem_c[i]),
            .part_root (root_c[i]),
            .rad_bits  (R[IN_W-1-2*i -: 2]),
            .new_rem   (rem_c[i+1]),
            .new_root  (root_c[i+1])
        );
    end

`ifdef MAHSQR_EXACT_LSB_EN
    assign root_nxt = root_c[N_STEPS];
`else
    rem_t       q9;
    rem_t       q2;
    rem_t       q3;
    rem_t       rem2;
    logic [1:0] lsb;

    assign q9   = rem_t'(root_c[K]);
    assign q2   = {q9[7:0], 1'b0};
    assign q3   = q9 + q2;
    assign rem2 = rem_t'({rem_c[K], 1'b0});

    // Lower bits estimate 2*rem/q, the first-order correction of sqrt(q^2+rem).
    always_comb begin
        lsb = 2'd0;
        if (q9 == '0) begin
            lsb = nibble_root(R[3:0]);
        end else if (rem2 >= q3) begin
            lsb = 2'd3;
        end else if (rem2 >= q2) begin
            lsb = 2'd2;
        end else if (rem2 >= q9) begin
            lsb = 2'd1;
        end
    end

    assign root_nxt = {root_c[K][5:0], lsb};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            final_op <= '0;
        end else begin
            final_op <= root_nxt;
        end
    end

endmodule

// File: tb/tb_squareroot_mahsqr_k6.sv
// Directed and exhaustive checks for squareroot_mahsqr_k6.
// Build option: MAHSQR_EXACT_LSB_EN expects floor(sqrt(R)) exactly.
module tb_squareroot_mahsqr_k6;

    logic        clk;
    logic        rst;
    logic [15:0] R;
    logic [7:0]  final_op;

    int checks;
    int errors;

    squareroot_mahsqr_k6 dut (
        .clk      (clk),
        .rst      (rst),
        .R        (R),
        .final_op (final_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int s;
        s = 0;
        while ((s + 1) * (s + 1) <= v) s++;
        return s;
    endfunction

    function automatic int model(input int r);
`ifdef MAHSQR_EXACT_LSB_EN
        return isqrt(r);
`else
        int h, q, rm, l;
        h  = r / 16;
        q  = isqrt(h);
        rm = h - q * q;
        if (q == 0) l = isqrt(r % 16);
        else if (2 * rm >= 3 * q) l = 3;
        else if (2 * rm >= 2 * q) l = 2;
        else if (2 * rm >= q) l = 1;
        else l = 0;
        return 4 * q + l;
`endif
    endfunction

    task automatic step(input logic [15:0] v);
        R = v;
        @(posedge clk);
        #1;
    endtask

    int dir_r   [12] = '{0, 3, 9, 10, 13, 15, 16'h3005, 16'hE600,
                         16'hFFFF, 16'h1E0B, 16'hE002, 16'h8799};
    int dir_exp [12] = '{0, 1, 3, 3, 3, 3, 110, 242, 255, 87, 239, 186};

    initial begin
        int fs;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        R = 16'h8799;
        @(posedge clk);
        #1;
        check("reset_c1", final_op, 0);
        @(posedge clk);
        #1;
        check("reset_c2", final_op, 0);
        rst = 1'b0;
        step(16'h8799);
        check("release", final_op, 186);

        for (int i = 0; i < 12; i++) begin
            step(16'(dir_r[i]));
            check($sformatf("dir_%0d", dir_r[i]), final_op, dir_exp[i]);
        end

        R = 16'hFFFF;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset", final_op, 0);
        rst = 1'b0;
        step(16'h1E0B);
        check("after_reset", final_op, 87);

        for (int r = 0; r < 65536; r++) begin
            step(16'(r));
            fs = isqrt(r);
            check($sformatf("sweep_%0d", r), final_op, model(r));
            check($sformatf("bound_%0d", r),
                  int'(final_op <= fs + 1 && final_op + 3 >= fs), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
